// File: rtl/ciphertext_loader.sv
// Ciphertext loader: gathers 16 UART bytes into a 128-bit block, using a four-phase
// Receive/ReceiveAck handshake. The block is published atomically, only when a complete
// frame arrives without error. Partial frames are dropped on timeout, parity error or clear.
module ciphertext_loader #(
  parameter int unsigned  CLK_FREQUENCY  = 100_000_000,
  parameter int unsigned  TIMEOUT_US     = 10_000,
  parameter logic [127:0] DEFAULT_CIPHER = 128'ha13a3ab3071897088f3233a58d6238bb
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  input  logic         rx_parity_err,
  input  logic         lock,
  input  logic         clear,
  output logic         rx_ack,
  output logic [127:0] cipher_out,
  output logic [4:0]   byte_count,
  output logic         load_done,
  output logic         frame_err
);

  localparam int unsigned TimeoutCycles = CLK_FREQUENCY / 1_000_000 * TIMEOUT_US;
  localparam int unsigned TimerW        = (TimeoutCycles >= 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TimeoutCycles - 1);

  typedef enum logic [0:0] {StWait, StAck} state_e;

  state_e            state_q;
  // Only the 15 most recent bytes need to be kept; the 16th comes straight from rx_data.
  logic [119:0]      asm_q;
  logic [TimerW-1:0] timer_q;
  logic              take_byte;

  // A byte is taken off the UART on the first WAIT cycle that sees rx_valid.
  always_comb begin
    take_byte = (state_q == StWait) && rx_valid && !lock;
  end

  // Handshake FSM, frame assembly and inter-byte timeout, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StWait;
      rx_ack     <= 1'b0;
      cipher_out <= DEFAULT_CIPHER;
      asm_q      <= '0;
      byte_count <= '0;
      timer_q    <= '0;
      load_done  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      frame_err <= 1'b0;

      // Handshake is independent of clear/lock: every byte gets acknowledged.
      unique case (state_q)
        StWait: begin
          if (rx_valid) begin
            state_q <= StAck;
            rx_ack  <= 1'b1;
          end
        end
        StAck: begin
          if (!rx_valid) begin
            state_q <= StWait;
            rx_ack  <= 1'b0;
          end
        end
      endcase

      // Priority: clear > capture (incl. parity drop) > timeout.
      if (clear) begin
        asm_q      <= '0;
        byte_count <= '0;
        timer_q    <= '0;
      end else if (take_byte && rx_parity_err) begin
        asm_q      <= '0;
        byte_count <= '0;
        timer_q    <= '0;
        frame_err  <= 1'b1;
      end else if (take_byte) begin
        asm_q   <= {asm_q[111:0], rx_data};
        timer_q <= '0;
        if (byte_count == 5'd15) begin
          cipher_out <= {asm_q, rx_data};
          load_done  <= 1'b1;
          byte_count <= '0;
        end else begin
          byte_count <= byte_count + 5'd1;
        end
      end else if ((state_q == StWait) && (byte_count != 5'd0)) begin
        if (timer_q == TimerMax) begin
          asm_q      <= '0;
          byte_count <= '0;
          timer_q    <= '0;
          frame_err  <= 1'b1;
        end else begin
          timer_q <= timer_q + TimerW'(1);
        end
      end else if (byte_count == 5'd0) begin
        timer_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ciphertext_loader.sv
// Directed bench for ciphertext_loader with a 100-cycle inter-byte timeout.
module tb_ciphertext_loader;

  localparam logic [127:0] DefCipher = 128'ha13a3ab3071897088f3233a58d6238bb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         rx_parity_err = 1'b0;
  logic         lock = 1'b0;
  logic         clear = 1'b0;
  logic         rx_ack;
  logic [127:0] cipher_out;
  logic [4:0]   byte_count;
  logic         load_done;
  logic         frame_err;

  int checks = 0;
  int errors = 0;
  int ld_cnt = 0;
  int fe_cnt = 0;
  int hs_cnt = 0;
  logic ack_prev = 1'b0;

  ciphertext_loader #(
    .CLK_FREQUENCY (100_000_000),
    .TIMEOUT_US    (1),
    .DEFAULT_CIPHER(DefCipher)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_parity_err(rx_parity_err),
    .lock         (lock),
    .clear        (clear),
    .rx_ack       (rx_ack),
    .cipher_out   (cipher_out),
    .byte_count   (byte_count),
    .load_done    (load_done),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse/handshake counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (load_done === 1'b1) ld_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
    if (rx_ack === 1'b1 && ack_prev !== 1'b1) hs_cnt++;
    ack_prev = rx_ack;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete four-phase handshake; waits are bounded.
  task automatic send(input logic [7:0] d, input logic pe, input logic lk);
    int n;
    @(negedge clk);
    rx_data = d; rx_parity_err = pe; lock = lk; rx_valid = 1'b1;
    n = 0;
    while (rx_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("ack_rise", {127'd0, rx_ack}, 128'd1);
    rx_valid = 1'b0; rx_parity_err = 1'b0; lock = 1'b0;
    n = 0;
    while (rx_ack !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("ack_fall", {127'd0, rx_ack}, 128'd0);
  endtask

  initial begin
    int ld0, fe0, hs0;

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cipher", cipher_out, DefCipher);
    check("rst_ack", {127'd0, rx_ack}, 128'd0);
    check("rst_count", {123'd0, byte_count}, 128'd0);
    check("rst_load_done", {127'd0, load_done}, 128'd0);
    check("rst_frame_err", {127'd0, frame_err}, 128'd0);

    // Full frame 00..0f
    ld0 = ld_cnt; hs0 = hs_cnt;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0, 1'b0);
      if (i < 15) begin
        check("frame_cipher_hold", cipher_out, DefCipher);
        check("frame_count", {123'd0, byte_count}, 128'(i + 1));
      end
    end
    check("frame_cipher", cipher_out, 128'h000102030405060708090a0b0c0d0e0f);
    check("frame_count_end", {123'd0, byte_count}, 128'd0);
    check("frame_load_done", 128'(ld_cnt - ld0), 128'd1);
    check("frame_handshakes", 128'(hs_cnt - hs0), 128'd16);

    // Long rx_valid: one capture, ack high T+1..T+10
    @(negedge clk);
    rx_data = 8'haa; rx_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("long_ack_high", {127'd0, rx_ack}, 128'd1);
      if (k == 10) rx_valid = 1'b0;
    end
    @(negedge clk);
    check("long_ack_low", {127'd0, rx_ack}, 128'd0);
    check("long_one_capture", {123'd0, byte_count}, 128'd1);
    // Clear the stray byte; clear gives no frame_err
    fe0 = fe_cnt;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_count", {123'd0, byte_count}, 128'd0);
    check("clear_no_ferr", 128'(fe_cnt - fe0), 128'd0);

    // Timeout after 5 bytes
    for (int i = 0; i < 5; i++) send(8'(8'h50 + i), 1'b0, 1'b0);
    check("to_count5", {123'd0, byte_count}, 128'd5);
    fe0 = fe_cnt;
    repeat (95) @(negedge clk);
    check("to_not_yet", {123'd0, byte_count}, 128'd5);
    repeat (7) @(negedge clk);
    check("to_count0", {123'd0, byte_count}, 128'd0);
    check("to_ferr_once", 128'(fe_cnt - fe0), 128'd1);
    check("to_cipher_hold", cipher_out, 128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0, 1'b0);
    check("to_next_frame", cipher_out, 128'h101112131415161718191a1b1c1d1e1f);

    // Parity error at count 7, then locked bytes
    for (int i = 0; i < 7; i++) send(8'(8'h60 + i), 1'b0, 1'b0);
    check("par_count7", {123'd0, byte_count}, 128'd7);
    fe0 = fe_cnt;
    send(8'h67, 1'b1, 1'b0);
    check("par_ferr", 128'(fe_cnt - fe0), 128'd1);
    check("par_count0", {123'd0, byte_count}, 128'd0);
    hs0 = hs_cnt;
    for (int i = 0; i < 4; i++) send(8'(8'h70 + i), 1'b0, 1'b1);
    check("lock_handshakes", 128'(hs_cnt - hs0), 128'd4);
    check("lock_count0", {123'd0, byte_count}, 128'd0);
    check("lock_cipher_hold", cipher_out, 128'h101112131415161718191a1b1c1d1e1f);

    // Clear on the capture edge of byte 16
    for (int i = 0; i < 15; i++) send(8'(8'h80 + i), 1'b0, 1'b0);
    check("coll_count15", {123'd0, byte_count}, 128'd15);
    ld0 = ld_cnt;
    @(negedge clk);
    rx_data = 8'h8f; rx_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("coll_ack", {127'd0, rx_ack}, 128'd1);
    check("coll_count0", {123'd0, byte_count}, 128'd0);
    check("coll_no_load", 128'(ld_cnt - ld0), 128'd0);
    check("coll_cipher_hold", cipher_out, 128'h101112131415161718191a1b1c1d1e1f);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("coll_ack_fall", {127'd0, rx_ack}, 128'd0);

    // Reset mid-frame
    for (int i = 0; i < 3; i++) send(8'(8'h90 + i), 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_count", {123'd0, byte_count}, 128'd0);
    check("mid_rst_cipher", cipher_out, DefCipher);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
